// File: rtl/game_tick_gen_pkg.sv
// game_tick_gen_pkg: shared game state codes, scan limits and tick-rate defaults.
package game_tick_gen_pkg;

    localparam logic [2:0] STATE_START  = 3'd0;
    localparam logic [2:0] STATE_INGAME = 3'd1;
    localparam logic [2:0] STATE_OVER   = 3'd2;

    localparam int LAST_HOR_ADDR   = 639;
    localparam int LAST_VER_ADDR   = 479;
    localparam int DEF_BASE_FRAMES = 8;
    localparam int DEF_MIN_FRAMES  = 2;
    localparam int DEF_SCORE_STEP  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } tick_state_e;

endpackage

// File: rtl/game_tick_gen_frame_end_detect.sv
// frame_end_detect: one registered strobe per frame end, immune to held scan coordinates.
module frame_end_detect #(
    parameter int H_LAST  = 639,
    parameter int V_LAST  = 479,
    parameter int COORD_W = 10
) (
    input  logic               in_clk,
    input  logic               sys_reset_n,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    output logic               fe_rise,
    output logic               frame_strobe
);

    logic fe;
    logic was_updated;

    assign fe      = (x_in == COORD_W'(H_LAST)) && (y_in == COORD_W'(V_LAST));
    assign fe_rise = fe && !was_updated;

    always_ff @(posedge in_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            was_updated  <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            was_updated  <= fe;
            frame_strobe <= fe_rise;
        end
    end

endmodule

// File: rtl/game_tick_gen.sv
// game_tick_gen: frame-divided game update tick with score-driven speed levels, pause and single-step.
module game_tick_gen
    import game_tick_gen_pkg::*;
#(
    parameter int H_LAST      = LAST_HOR_ADDR,
    parameter int V_LAST      = LAST_VER_ADDR,
    parameter int COORD_W     = 10,
    parameter int SCORE_W     = 8,
    parameter int BASE_FRAMES = DEF_BASE_FRAMES,
    parameter int MIN_FRAMES  = DEF_MIN_FRAMES,
    parameter int LEVEL_DEC   = 1,
    parameter int SCORE_STEP  = DEF_SCORE_STEP,
    parameter int LEVELS      = 8,
    parameter int FPT_W       = 4
) (
    input  logic                       in_clk,
    input  logic                       sys_reset_n,
    input  logic [COORD_W-1:0]         x_in,
    input  logic [COORD_W-1:0]         y_in,
    input  logic [2:0]                 game_state,
    input  logic [SCORE_W-1:0]         score,
    input  logic                       pause,
    input  logic                       step,
    output logic                       tick,
    output logic                       frame_strobe,
    output logic [$clog2(LEVELS)-1:0]  level,
    output logic [FPT_W-1:0]           frames_per_tick,
    output logic                       paused
);

    localparam int LW    = $clog2(LEVELS);
    localparam int CW    = FPT_W + LW + 1;
    localparam int SHIFT = $clog2(SCORE_STEP);

    logic               fe_rise;
    logic               ingame;
    logic               step_q;
    logic               step_pend;
    logic [SCORE_W-1:0] lvl_wide;
    logic [LW-1:0]      lvl_raw;
    logic [CW-1:0]      dec;
    logic [FPT_W-1:0]   fpt_raw;
    logic [FPT_W-1:0]   cnt;
    tick_state_e        state;

    frame_end_detect #(
        .H_LAST  (H_LAST),
        .V_LAST  (V_LAST),
        .COORD_W (COORD_W)
    ) u_fed (
        .in_clk       (in_clk),
        .sys_reset_n  (sys_reset_n),
        .x_in         (x_in),
        .y_in         (y_in),
        .fe_rise      (fe_rise),
        .frame_strobe (frame_strobe)
    );

    assign ingame = game_state == STATE_INGAME;

    // Wide intermediate keeps BASE - lvl*DEC from wrapping before the MIN clamp.
    always_comb begin
        lvl_wide = score >> SHIFT;
        lvl_raw  = (lvl_wide > SCORE_W'(LEVELS - 1)) ? LW'(LEVELS - 1) : lvl_wide[LW-1:0];
        dec      = CW'(lvl_raw) * CW'(LEVEL_DEC);
        fpt_raw  = (dec + CW'(MIN_FRAMES) > CW'(BASE_FRAMES)) ? FPT_W'(MIN_FRAMES)
                                                             : FPT_W'(CW'(BASE_FRAMES) - dec);
    end

    always_ff @(posedge in_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            tick            <= 1'b0;
            level           <= '0;
            frames_per_tick <= FPT_W'(BASE_FRAMES);
            paused          <= 1'b0;
            step_q          <= 1'b0;
            step_pend       <= 1'b0;
        end else begin
            step_q <= step;
            tick   <= 1'b0;
            if (!ingame) begin
                state     <= IDLE;
                cnt       <= '0;
                paused    <= 1'b0;
                step_pend <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state           <= RUN;
                        cnt             <= '0;
                        level           <= lvl_raw;
                        frames_per_tick <= fpt_raw;
                    end
                    RUN: begin
                        if (pause) begin
                            state  <= PAUSED;
                            paused <= 1'b1;
                        end else if (fe_rise) begin
                            // >= lets a divisor that shrank under the counter wrap on the next frame.
                            if (cnt >= frames_per_tick - FPT_W'(1)) begin
                                cnt             <= '0;
                                tick            <= 1'b1;
                                level           <= lvl_raw;
                                frames_per_tick <= fpt_raw;
                            end else begin
                                cnt <= cnt + FPT_W'(1);
                            end
                        end
                    end
                    PAUSED: begin
                        if (!pause) begin
                            state     <= RUN;
                            paused    <= 1'b0;
                            step_pend <= 1'b0;
                        end else if (step_pend && fe_rise) begin
                            tick            <= 1'b1;
                            step_pend       <= 1'b0;
                            level           <= lvl_raw;
                            frames_per_tick <= fpt_raw;
                        end else if (step && !step_q) begin
                            step_pend <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_tick_gen.sv
// tb_game_tick_gen: directed frames with hand-computed expectations checked by a strobe-driven scoreboard.
module tb_game_tick_gen;
    import game_tick_gen_pkg::*;

    typedef struct {
        logic       t;
        logic [2:0] l;
        logic [3:0] f;
    } exp_t;

    logic       in_clk = 1'b0;
    logic       sys_reset_n = 1'b0;
    logic [9:0] x_in = '0;
    logic [9:0] y_in = '0;
    logic [2:0] game_state = STATE_START;
    logic [7:0] score = '0;
    logic       pause = 1'b0;
    logic       step = 1'b0;
    logic       tick;
    logic       frame_strobe;
    logic [2:0] level;
    logic [3:0] frames_per_tick;
    logic       paused;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   strobes = 0;

    game_tick_gen dut (
        .in_clk          (in_clk),
        .sys_reset_n     (sys_reset_n),
        .x_in            (x_in),
        .y_in            (y_in),
        .game_state      (game_state),
        .score           (score),
        .pause           (pause),
        .step            (step),
        .tick            (tick),
        .frame_strobe    (frame_strobe),
        .level           (level),
        .frames_per_tick (frames_per_tick),
        .paused          (paused)
    );

    always #5 in_clk = ~in_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    always @(negedge in_clk) begin
        if (tick && !frame_strobe) begin
            checks++;
            errors++;
            $display("FAIL tick_without_strobe tick=%0b strobe=%0b", tick, frame_strobe);
        end
        if (frame_strobe) begin
            exp_t e;
            strobes++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got tick=%0b level=%0d fpt=%0d", tick, level, frames_per_tick);
            end else begin
                e = q.pop_front();
                if (tick !== e.t || level !== e.l || frames_per_tick !== e.f) begin
                    errors++;
                    $display("FAIL strobe_%0d got tick=%0b level=%0d fpt=%0d want tick=%0b level=%0d fpt=%0d",
                             strobes, tick, level, frames_per_tick, e.t, e.l, e.f);
                end
            end
        end
    end

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    task automatic frame(input logic t, input logic [2:0] l, input logic [3:0] f);
        q.push_back('{t, l, f});
        @(negedge in_clk);
        x_in = 10'd639;
        y_in = 10'd479;
        @(negedge in_clk);
        x_in = 10'd0;
        y_in = 10'd0;
        repeat (3) @(negedge in_clk);
    endtask

    task automatic frames(input int n, input logic [2:0] l, input logic [3:0] f);
        for (int i = 0; i < n; i++) frame(1'b0, l, f);
    endtask

    initial begin
        int s0;
        game_state = STATE_INGAME;
        #200;
        check("rst_tick", 8'(tick), 8'd0);
        check("rst_strobe", 8'(frame_strobe), 8'd0);
        check("rst_level", 8'(level), 8'd0);
        check("rst_fpt", 8'(frames_per_tick), 8'd8);
        check("rst_paused", 8'(paused), 8'd0);
        @(negedge in_clk);
        sys_reset_n = 1'b1;
        repeat (2) @(negedge in_clk);
        // level 0: tick every 8 frames
        frames(7, 3'd0, 4'd8);
        frame(1'b1, 3'd0, 4'd8);
        frames(7, 3'd0, 4'd8);
        frame(1'b1, 3'd0, 4'd8);
        // score 12 mid-period: period stays 8, then level 3 / 5 frames
        frames(3, 3'd0, 4'd8);
        score = 8'd12;
        frames(4, 3'd0, 4'd8);
        frame(1'b1, 3'd3, 4'd5);
        frames(4, 3'd3, 4'd5);
        frame(1'b1, 3'd3, 4'd5);
        // score 255: level clamps at 7, divisor clamps at 2
        score = 8'd255;
        frames(4, 3'd3, 4'd5);
        frame(1'b1, 3'd7, 4'd2);
        frame(1'b0, 3'd7, 4'd2);
        frame(1'b1, 3'd7, 4'd2);
        frame(1'b0, 3'd7, 4'd2);
        frame(1'b1, 3'd7, 4'd2);
        // held coordinates: exactly one strobe
        s0 = strobes;
        q.push_back('{1'b0, 3'd7, 4'd2});
        @(negedge in_clk);
        x_in = 10'd639;
        y_in = 10'd479;
        repeat (50) @(negedge in_clk);
        x_in = 10'd0;
        y_in = 10'd0;
        repeat (3) @(negedge in_clk);
        check("frozen_strobes", 8'(strobes - s0), 8'd1);
        score = 8'd0;
        frame(1'b1, 3'd0, 4'd8);
        // pause after 4 frames, step once, resume
        frames(4, 3'd0, 4'd8);
        pause = 1'b1;
        repeat (2) @(negedge in_clk);
        check("paused_on", 8'(paused), 8'd1);
        frames(20, 3'd0, 4'd8);
        step = 1'b1;
        @(negedge in_clk);
        step = 1'b0;
        frame(1'b1, 3'd0, 4'd8);
        check("paused_after_step", 8'(paused), 8'd1);
        pause = 1'b0;
        repeat (2) @(negedge in_clk);
        check("paused_off", 8'(paused), 8'd0);
        frames(3, 3'd0, 4'd8);
        frame(1'b1, 3'd0, 4'd8);
        // leave INGAME at counter 6, counter restarts on return
        frames(6, 3'd0, 4'd8);
        game_state = STATE_START;
        repeat (2) @(negedge in_clk);
        frames(2, 3'd0, 4'd8);
        game_state = STATE_INGAME;
        repeat (2) @(negedge in_clk);
        frames(7, 3'd0, 4'd8);
        score = 8'd255;
        frame(1'b1, 3'd7, 4'd2);
        // async reset while paused with a strobe in flight
        pause = 1'b1;
        repeat (2) @(negedge in_clk);
        check("paused_pre_rst", 8'(paused), 8'd1);
        x_in = 10'd639;
        y_in = 10'd479;
        @(posedge in_clk);
        #2;
        check("strobe_pre_rst", 8'(frame_strobe), 8'd1);
        strobes--;
        sys_reset_n = 1'b0;
        #1;
        check("arst_strobe", 8'(frame_strobe), 8'd0);
        check("arst_level", 8'(level), 8'd0);
        check("arst_fpt", 8'(frames_per_tick), 8'd8);
        check("arst_paused", 8'(paused), 8'd0);
        check("arst_tick", 8'(tick), 8'd0);
        repeat (3) @(negedge in_clk);
        check("queue_empty", 8'(q.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
